// File: rtl/sccb_target_if.sv
// SCCB pin bundle plus the configuration-write observation port of the OV5642-style target.
// The slave side is the target; the master side is the initiator/bench that drives SIOC/SIOD.
interface sccb_target_if;
  logic        i_sioc;
  logic        i_siod_in;
  logic        o_siod_out;
  logic        o_siod_oe;
  logic        o_wr_strobe;
  logic [15:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_busy;
  logic [15:0] o_addr_ptr;

  modport slave (
    input  i_sioc, i_siod_in,
    output o_siod_out, o_siod_oe, o_wr_strobe, o_wr_addr, o_wr_data, o_busy, o_addr_ptr
  );

  modport master (
    output i_sioc, i_siod_in,
    input  o_siod_out, o_siod_oe, o_wr_strobe, o_wr_addr, o_wr_data, o_busy, o_addr_ptr
  );
endinterface

// File: rtl/sccb_target.sv
// SCCB responder modelling the OV5642 register file; pins are oversampled by i_clk, 3-cycle pin-to-event latency.
// No backpressure: the initiator owns SIOC, the target only ACKs/NAs and drives read bits between SIOC falling edges.
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h3C,
  parameter int          IDX_W  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  sccb_target_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ACK_ID, S_ADDR_H, S_ACK_H, S_ADDR_L, S_ACK_L,
    S_WDATA, S_ACK_W, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  logic        sioc_s1, sioc_s2, sioc_h;
  logic        siod_s1, siod_s2, siod_h;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [7:0]  sh, sh_nx;
  logic        rd_mode, rd_nx;
  logic [15:0] ptr, ptr_nx;
  logic        oe, oe_nx, sdo, sdo_nx, busy, busy_nx;
  logic        stb, stb_nx, we;
  logic [15:0] wr_addr, waddr_nx;
  logic [7:0]  wr_data, wdata_nx;
  logic [7:0]  regfile [2**IDX_W];
  logic [7:0]  cur_byte;

  wire sioc_rise = sioc_s2 & ~sioc_h;
  wire sioc_fall = ~sioc_s2 & sioc_h;
  // SIOC high alone qualifies start/stop so they win over a coincident SIOC edge.
  wire start_det = sioc_s2 & siod_h & ~siod_s2;
  wire stop_det  = sioc_s2 & ~siod_h & siod_s2;

  assign cur_byte = regfile[ptr[IDX_W-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {sioc_s1, sioc_s2, sioc_h} <= 3'b111;
      {siod_s1, siod_s2, siod_h} <= 3'b111;
      state   <= S_IDLE;
      cnt     <= 4'd0;
      sh      <= 8'h00;
      rd_mode <= 1'b0;
      ptr     <= 16'h0000;
      oe      <= 1'b0;
      sdo     <= 1'b1;
      busy    <= 1'b0;
      stb     <= 1'b0;
      wr_addr <= 16'h0000;
      wr_data <= 8'h00;
    end else begin
      {sioc_s1, sioc_s2, sioc_h} <= {bus.i_sioc, sioc_s1, sioc_s2};
      {siod_s1, siod_s2, siod_h} <= {bus.i_siod_in, siod_s1, siod_s2};
      state   <= state_nx;
      cnt     <= cnt_nx;
      sh      <= sh_nx;
      rd_mode <= rd_nx;
      ptr     <= ptr_nx;
      oe      <= oe_nx;
      sdo     <= sdo_nx;
      busy    <= busy_nx;
      stb     <= stb_nx;
      wr_addr <= waddr_nx;
      wr_data <= wdata_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) regfile[i] <= 8'h00;
    end else if (we) begin
      regfile[ptr[IDX_W-1:0]] <= wdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    rd_nx    = rd_mode;
    ptr_nx   = ptr;
    oe_nx    = oe;
    sdo_nx   = sdo;
    busy_nx  = busy;
    stb_nx   = 1'b0;
    waddr_nx = wr_addr;
    wdata_nx = wr_data;
    we       = 1'b0;
    if (stop_det) begin
      state_nx = S_IDLE;
      cnt_nx   = 4'd0;
      oe_nx    = 1'b0;
      sdo_nx   = 1'b1;
      busy_nx  = 1'b0;
    end else if (start_det) begin
      state_nx = S_ID;
      cnt_nx   = 4'd0;
      oe_nx    = 1'b0;
      sdo_nx   = 1'b1;
      busy_nx  = 1'b1;
    end else begin
      case (state)
        S_ID, S_ADDR_H, S_ADDR_L, S_WDATA, S_RDATA: begin
          if (sioc_rise && cnt != 4'd8) begin
            sh_nx  = {sh[6:0], siod_s2};
            cnt_nx = cnt + 4'd1;
            if (state == S_WDATA && cnt == 4'd7) begin
              we       = 1'b1;
              stb_nx   = 1'b1;
              waddr_nx = ptr;
              wdata_nx = sh_nx;
              ptr_nx   = ptr + 16'd1;
            end
          end else if (sioc_fall && cnt == 4'd8) begin
            oe_nx  = 1'b1;
            sdo_nx = 1'b0;
            case (state)
              S_ID: begin
                if (sh == {DEV_ID, 1'b0}) begin
                  state_nx = S_ACK_ID;
                  rd_nx    = 1'b0;
                end else if (sh == {DEV_ID, 1'b1}) begin
                  state_nx = S_ACK_ID;
                  rd_nx    = 1'b1;
                end else begin
                  state_nx = S_IGNORE;
                  oe_nx    = 1'b0;
                  sdo_nx   = 1'b1;
                end
              end
              S_ADDR_H: begin
                ptr_nx[15:8] = sh;
                state_nx     = S_ACK_H;
              end
              S_ADDR_L: begin
                ptr_nx[7:0] = sh;
                state_nx    = S_ACK_L;
              end
              S_WDATA: state_nx = S_ACK_W;
              default: begin
                // Read byte done: hand SIOD back for the initiator's ACK/NA.
                oe_nx    = 1'b0;
                sdo_nx   = 1'b1;
                ptr_nx   = ptr + 16'd1;
                state_nx = S_RACK;
              end
            endcase
          end else if (sioc_fall && state == S_RDATA) begin
            sdo_nx = cur_byte[3'(4'd7 - cnt)];
          end
        end
        S_ACK_ID, S_ACK_H, S_ACK_L, S_ACK_W, S_RACK: begin
          // Entered with cnt=8; the 9th rising edge clears it, arming the exit on the next fall.
          if (sioc_rise) begin
            cnt_nx = 4'd0;
            sh_nx  = {sh[6:0], siod_s2};
          end else if (sioc_fall && cnt == 4'd0) begin
            oe_nx  = 1'b0;
            sdo_nx = 1'b1;
            case (state)
              S_ACK_ID: begin
                if (rd_mode) begin
                  state_nx = S_RDATA;
                  oe_nx    = 1'b1;
                  sdo_nx   = cur_byte[7];
                end else begin
                  state_nx = S_ADDR_H;
                end
              end
              S_ACK_H: state_nx = S_ADDR_L;
              S_ACK_L, S_ACK_W: state_nx = S_WDATA;
              default: begin
                if (!sh[0]) begin
                  state_nx = S_RDATA;
                  oe_nx    = 1'b1;
                  sdo_nx   = cur_byte[7];
                end else begin
                  state_nx = S_IGNORE;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_siod_out  = sdo;
  assign bus.o_siod_oe   = oe;
  assign bus.o_wr_strobe = stb;
  assign bus.o_wr_addr   = wr_addr;
  assign bus.o_wr_data   = wr_data;
  assign bus.o_busy      = busy;
  assign bus.o_addr_ptr  = ptr;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator on an open-drain SIOD, with a byte-array register model.
`timescale 1ns/1ps
module tb_sccb_target;
  localparam int H = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [256];
  logic [15:0] mptr;
  logic [23:0] stb_log [1024];
  int stb_n = 0;
  int oe_cycles = 0;

  sccb_target_if bus();
  assign bus.i_sioc    = m_scl;
  assign bus.i_siod_in = m_sda & (bus.o_siod_oe ? bus.o_siod_out : 1'b1);

  sccb_target #(.DEV_ID(7'h3C), .IDX_W(8)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (bus.o_wr_strobe) begin
      stb_log[stb_n % 1024] <= {bus.o_wr_addr, bus.o_wr_data};
      stb_n <= stb_n + 1;
    end
    if (bus.o_siod_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge i_clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; clks(H);
    m_scl = 1'b1; clks(H);
    m_sda = 1'b0; clks(H);
    m_scl = 1'b0; clks(2);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; clks(H);
    m_scl = 1'b1; clks(H);
    m_sda = 1'b1; clks(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; clks(H);
      m_scl = 1'b1;   clks(H);
      m_scl = 1'b0;   clks(2);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic nack);
    send_bits(b, 8);
    m_sda = 1'b1; clks(H);
    m_scl = 1'b1; clks(H/2);
    #1 nack = bus.i_siod_in;
    clks(H/2);
    m_scl = 1'b0; clks(2);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clks(H);
      m_scl = 1'b1; clks(H/2);
      #1 b[7-i] = bus.i_siod_in;
      clks(H/2);
      m_scl = 1'b0;
    end
    clks(2);
    m_sda = ~mack; clks(H);
    m_scl = 1'b1;  clks(H);
    m_scl = 1'b0;  clks(2);
    m_sda = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d [4], input int n, output int nacks);
    logic na;
    nacks = 0;
    bus_start();
    write_byte(8'h78, na);   nacks += int'(na);
    write_byte(a[15:8], na); nacks += int'(na);
    write_byte(a[7:0], na);  nacks += int'(na);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], na); nacks += int'(na);
    end
    bus_stop();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output logic [7:0] q [4], output int nacks);
    logic na;
    nacks = 0;
    bus_start();
    write_byte(8'h78, na);   nacks += int'(na);
    write_byte(a[15:8], na); nacks += int'(na);
    write_byte(a[7:0], na);  nacks += int'(na);
    bus_stop();
    bus_start();
    write_byte(8'h79, na);   nacks += int'(na);
    for (int i = 0; i < n; i++) read_byte(i != n-1, q[i]);
    bus_stop();
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d [4], input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ad;
      ad = a + 16'(i);
      mem[ad[7:0]] = d[i];
    end
    mptr = a + 16'(n);
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.o_siod_oe, bus.o_siod_out, bus.o_wr_strobe, bus.o_busy} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0100", {bus.o_siod_oe, bus.o_siod_out, bus.o_wr_strobe, bus.o_busy});
    end
    vectors++;
    if ({bus.o_wr_addr, bus.o_wr_data, bus.o_addr_ptr} !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_regs got %h exp 0", {bus.o_wr_addr, bus.o_wr_data, bus.o_addr_ptr});
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d [4];
    logic [7:0] q [4];
    int nacks, s;
    d = '{8'h82, 8'h00, 8'h00, 8'h00};
    s = stb_n;
    do_write(16'h3008, d, 1, nacks);
    model_write(16'h3008, d, 1);
    vectors++;
    if (nacks !== 0) begin miscompares++; $display("FAIL wr_acks got %0d nacks exp 0", nacks); end
    vectors++;
    if (stb_n - s !== 1) begin miscompares++; $display("FAIL wr_strobe_count got %0d exp 1", stb_n - s); end
    vectors++;
    if (stb_log[s % 1024] !== {16'h3008, 8'h82}) begin
      miscompares++; $display("FAIL wr_strobe got %h exp 300882", stb_log[s % 1024]);
    end
    do_read(16'h3008, 1, q, nacks);
    mptr = 16'h3009;
    vectors++;
    if (q[0] !== mem[8'h08] || nacks !== 0) begin
      miscompares++; $display("FAIL rd_3008 got %h/%0d exp %h/0", q[0], nacks, mem[8'h08]);
    end
    vectors++;
    if (bus.o_busy !== 1'b0 || bus.o_addr_ptr !== mptr) begin
      miscompares++; $display("FAIL rd_after busy=%b ptr=%h exp 0/%h", bus.o_busy, bus.o_addr_ptr, mptr);
    end
    bus_start();
    vectors++;
    if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_start got %b exp 1", bus.o_busy); end
    bus_stop();
  endtask

  task automatic test_wrong_id();
    logic [7:0] d [4];
    logic na, dummy;
    int s, o0, nacks;
    s = stb_n; o0 = oe_cycles;
    bus_start();
    write_byte(8'h42, na);
    write_byte(8'h30, dummy);
    write_byte(8'h08, dummy);
    write_byte(8'h55, dummy);
    bus_stop();
    vectors++;
    if (na !== 1'b1) begin miscompares++; $display("FAIL badid_ack got %b exp 1", na); end
    vectors++;
    if (oe_cycles !== o0 || stb_n !== s) begin
      miscompares++; $display("FAIL badid_quiet oe_cycles=%0d strobes=%0d exp 0/0", oe_cycles - o0, stb_n - s);
    end
    vectors++;
    if (bus.o_addr_ptr !== mptr) begin miscompares++; $display("FAIL badid_ptr got %h exp %h", bus.o_addr_ptr, mptr); end
    d = '{8'h93, 8'h00, 8'h00, 8'h00};
    s = stb_n;
    do_write(16'h3103, d, 1, nacks);
    model_write(16'h3103, d, 1);
    vectors++;
    if (nacks !== 0 || stb_n - s !== 1 || stb_log[s % 1024] !== {16'h3103, 8'h93}) begin
      miscompares++; $display("FAIL after_badid got %h n=%0d nacks=%0d exp 310393", stb_log[s % 1024], stb_n - s, nacks);
    end
  endtask

  task automatic check_write(input logic [15:0] a, input logic [7:0] d [4], input int n, input int s, input int nacks);
    vectors++;
    if (nacks !== 0 || stb_n - s !== n) begin
      miscompares++; $display("FAIL burst_count nacks=%0d strobes=%0d exp 0/%0d", nacks, stb_n - s, n);
    end
    for (int i = 0; i < n; i++) begin
      logic [23:0] exp;
      exp = {a + 16'(i), d[i]};
      vectors++;
      if (stb_log[(s + i) % 1024] !== exp) begin
        miscompares++; $display("FAIL strobe%0d got %h exp %h", i, stb_log[(s + i) % 1024], exp);
      end
    end
  endtask

  task automatic check_read(input logic [15:0] a, input int n);
    logic [7:0] q [4];
    int nacks;
    do_read(a, n, q, nacks);
    mptr = a + 16'(n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ad;
      ad = a + 16'(i);
      vectors++;
      if (q[i] !== mem[ad[7:0]]) begin
        miscompares++; $display("FAIL read %h got %h exp %h", ad, q[i], mem[ad[7:0]]);
      end
    end
    vectors++;
    if (nacks !== 0 || bus.o_addr_ptr !== mptr) begin
      miscompares++; $display("FAIL read_ptr got %h nacks=%0d exp %h/0", bus.o_addr_ptr, nacks, mptr);
    end
  endtask

  task automatic test_burst();
    logic [7:0] d [4];
    int s, nacks;
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    s = stb_n;
    do_write(16'h30FF, d, 3, nacks);
    model_write(16'h30FF, d, 3);
    check_write(16'h30FF, d, 3, s, nacks);
    check_read(16'h30FF, 3);
    d = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    s = stb_n;
    do_write(16'hFFFF, d, 2, nacks);
    model_write(16'hFFFF, d, 2);
    check_write(16'hFFFF, d, 2, s, nacks);
    vectors++;
    if (bus.o_addr_ptr !== 16'h0001) begin miscompares++; $display("FAIL ptr_wrap got %h exp 0001", bus.o_addr_ptr); end
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [15:0] a;
    int n, s, nacks;
    for (int t = 0; t < 6; t++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      s = stb_n;
      do_write(a, d, n, nacks);
      model_write(a, d, n);
      check_write(a, d, n, s, nacks);
      check_read(a, n);
      check_read(16'($urandom), 1);
    end
  endtask

  task automatic test_partial_stop();
    logic [15:0] a;
    logic na;
    int s, nacks;
    a = 16'($urandom);
    s = stb_n;
    nacks = 0;
    bus_start();
    write_byte(8'h78, na); nacks += int'(na);
    write_byte(a[15:8], na); nacks += int'(na);
    write_byte(a[7:0], na); nacks += int'(na);
    send_bits(8'hA5, 5);
    bus_stop();
    mptr = a;
    vectors++;
    if (nacks !== 0 || stb_n !== s || bus.o_addr_ptr !== a || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_stop nacks=%0d strobes=%0d ptr=%h busy=%b exp 0/0/%h/0", nacks, stb_n - s, bus.o_addr_ptr, bus.o_busy, a);
    end
    check_read(a, 1);
  endtask

  task automatic test_rep_start();
    logic [15:0] a;
    logic [7:0] q;
    logic na;
    int nacks;
    a = 16'h30FF + 16'($urandom_range(0, 2));
    nacks = 0;
    bus_start();
    write_byte(8'h78, na); nacks += int'(na);
    write_byte(a[15:8], na); nacks += int'(na);
    write_byte(a[7:0], na); nacks += int'(na);
    bus_start();
    write_byte(8'h79, na); nacks += int'(na);
    read_byte(1'b0, q);
    bus_stop();
    mptr = a + 16'd1;
    vectors++;
    if (nacks !== 0 || q !== mem[a[7:0]] || bus.o_addr_ptr !== mptr) begin
      miscompares++;
      $display("FAIL rep_start got %h ptr=%h nacks=%0d exp %h/%h/0", q, bus.o_addr_ptr, nacks, mem[a[7:0]], mptr);
    end
  endtask

  task automatic test_reset_ack();
    bus_start();
    send_bits(8'h78, 8);
    m_sda = 1'b1;
    clks(6);
    #1;
    vectors++;
    if (bus.o_siod_oe !== 1'b1) begin miscompares++; $display("FAIL ack_drive got oe=%b exp 1", bus.o_siod_oe); end
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_siod_oe, bus.o_siod_out} !== 2'b01) begin
      miscompares++; $display("FAIL async_release got %b exp 01", {bus.o_siod_oe, bus.o_siod_out});
    end
    clks(3);
    i_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mptr = 16'h0000;
    bus_stop();
    test_reset();
    check_read(16'h3008, 1);
    check_read(16'h30FF, 3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mptr = 16'h0000;
    clks(5);
    #1;
    test_reset();
    i_rst_n = 1'b1;
    clks(5);
    test_write_read();
    test_wrong_id();
    test_burst();
    test_random();
    test_partial_stop();
    test_rep_start();
    test_reset_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
